// File: rtl/snax_gemmx_d32_serializer.sv
// Splits one wide GEMM D32 result word into Ratio narrow beats for the streamer, lowest slice first.
// Optional beat counter output enabled by defining SNAX_GEMMX_SER_BEAT_CNT_EN.
module snax_gemmx_d32_serializer #(
    parameter int unsigned WideWidth   = 2048,
    parameter int unsigned NarrowWidth = 512,
    parameter int unsigned CntWidth    = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic [WideWidth-1:0]   acc_data_i,
    input  logic                   acc_valid_i,
    output logic                   acc_ready_o,
    output logic [NarrowWidth-1:0] stream_data_o,
    output logic                   stream_valid_o,
    input  logic                   stream_ready_i,
    output logic                   busy_o
`ifdef SNAX_GEMMX_SER_BEAT_CNT_EN
    ,
    output logic [CntWidth-1:0]    beat_cnt_o
`endif
);

    localparam int unsigned Ratio    = WideWidth / NarrowWidth;
    localparam int unsigned IdxWidth = (Ratio > 1) ? $clog2(Ratio) : 1;
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(Ratio - 1);

    generate
        if ((WideWidth % NarrowWidth) != 0 || Ratio < 2) begin : gen_ratio_check
            $error("WideWidth must be an integer multiple (>= 2) of NarrowWidth");
        end
    endgenerate

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e                 state_r;
    logic [IdxWidth-1:0]    idx_r;
    logic [WideWidth-1:0]   held_r;

    logic last_s;
    logic acc_ready_s;
    logic stream_valid_s;
    logic accept_s;
    logic beat_s;

    // Handshake decode; clear_i masks both directions in the cycle it is high.
    always_comb begin
        last_s         = (idx_r == LastIdx);
        acc_ready_s    = 1'b0;
        stream_valid_s = 1'b0;
        if (clear_i) begin
            acc_ready_s    = 1'b0;
            stream_valid_s = 1'b0;
        end else if (state_r == IDLE) begin
            acc_ready_s    = 1'b1;
            stream_valid_s = 1'b0;
        end else begin
            acc_ready_s    = last_s & stream_ready_i;
            stream_valid_s = 1'b1;
        end
        accept_s = acc_valid_i & acc_ready_s;
        beat_s   = stream_valid_s & stream_ready_i;
    end

    // Serializer FSM: holds the word and walks idx across its slices.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
            idx_r   <= '0;
            held_r  <= '0;
        end else if (clear_i) begin
            state_r <= IDLE;
            idx_r   <= '0;
            held_r  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        held_r  <= acc_data_i;
                        idx_r   <= '0;
                        state_r <= SEND;
                    end
                end
                SEND: begin
                    if (beat_s) begin
                        if (last_s) begin
                            idx_r <= '0;
                            if (accept_s) begin
                                held_r  <= acc_data_i;
                                state_r <= SEND;
                            end else begin
                                state_r <= IDLE;
                            end
                        end else begin
                            idx_r <= idx_r + IdxWidth'(1);
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    idx_r   <= '0;
                end
            endcase
        end
    end

    assign acc_ready_o    = acc_ready_s;
    assign stream_valid_o = stream_valid_s;
    assign stream_data_o  = held_r[idx_r*NarrowWidth +: NarrowWidth];
    assign busy_o         = (state_r == SEND);

`ifdef SNAX_GEMMX_SER_BEAT_CNT_EN
    logic [CntWidth-1:0] beat_cnt_r;

    // Free-running beat counter, wraps naturally at 2^CntWidth.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_cnt_r <= '0;
        end else if (clear_i) begin
            beat_cnt_r <= '0;
        end else if (beat_s) begin
            beat_cnt_r <= beat_cnt_r + CntWidth'(1);
        end else begin
            beat_cnt_r <= beat_cnt_r;
        end
    end

    assign beat_cnt_o = beat_cnt_r;
`endif

endmodule

// File: tb/tb_snax_gemmx_d32_serializer.sv
// Directed self-checking bench for snax_gemmx_d32_serializer with Ratio = 4 (128-bit word, 32-bit beats).
module tb_snax_gemmx_d32_serializer;

    localparam int WW = 128;
    localparam int NW = 32;
    localparam int CW = 32;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          clear_i;
    logic [WW-1:0] acc_data_i;
    logic          acc_valid_i;
    logic          acc_ready_o;
    logic [NW-1:0] stream_data_o;
    logic          stream_valid_o;
    logic          stream_ready_i;
    logic          busy_o;
`ifdef SNAX_GEMMX_SER_BEAT_CNT_EN
    logic [CW-1:0] beat_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    logic [WW-1:0] w1;
    logic [WW-1:0] words [3];
    logic [WW-1:0] w5;
    logic [WW-1:0] w6;
    logic [WW-1:0] w7;
    logic [WW-1:0] w8;

    snax_gemmx_d32_serializer #(
        .WideWidth  (WW),
        .NarrowWidth(NW),
        .CntWidth   (CW)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clear_i       (clear_i),
        .acc_data_i    (acc_data_i),
        .acc_valid_i   (acc_valid_i),
        .acc_ready_o   (acc_ready_o),
        .stream_data_o (stream_data_o),
        .stream_valid_o(stream_valid_o),
        .stream_ready_i(stream_ready_i),
        .busy_o        (busy_o)
`ifdef SNAX_GEMMX_SER_BEAT_CNT_EN
        ,
        .beat_cnt_o    (beat_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #2;
    endtask

    task automatic beat_chk(input string tag, input logic [NW-1:0] exp_data, input logic exp_ardy);
        chk({tag, "_valid"}, WW'(stream_valid_o), WW'(1'b1));
        chk({tag, "_data"}, WW'(stream_data_o), WW'(exp_data));
        chk({tag, "_ardy"}, WW'(acc_ready_o), WW'(exp_ardy));
        chk({tag, "_busy"}, WW'(busy_o), WW'(1'b1));
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_valid"}, WW'(stream_valid_o), WW'(1'b0));
        chk({tag, "_busy"}, WW'(busy_o), WW'(1'b0));
        chk({tag, "_ardy"}, WW'(acc_ready_o), WW'(1'b1));
    endtask

    initial begin
        int exp_i;
        int cyc;
        logic rdy;
        w1       = {32'hD, 32'hC, 32'hB, 32'hA};
        words[0] = {32'h23, 32'h22, 32'h21, 32'h20};
        words[1] = {32'h33, 32'h32, 32'h31, 32'h30};
        words[2] = {32'h43, 32'h42, 32'h41, 32'h40};
        w5       = {32'h53, 32'h52, 32'h51, 32'h50};
        w6       = {32'h63, 32'h62, 32'h61, 32'h60};
        w7       = {32'h73, 32'h72, 32'h71, 32'h70};
        w8       = {32'h83, 32'h82, 32'h81, 32'h80};

        // Reset state
        rst_ni = 1'b0; clear_i = 1'b0; acc_valid_i = 1'b0; acc_data_i = '0; stream_ready_i = 1'b0;
        #3;
        idle_chk("reset");
        chk("reset_data", WW'(stream_data_o), WW'(32'h0));
`ifdef SNAX_GEMMX_SER_BEAT_CNT_EN
        chk("reset_cnt", WW'(beat_cnt_o), WW'(32'h0));
`endif
        #9 rst_ni = 1'b1;
        next_cycle();

        // Single word, ready always high
        stream_ready_i = 1'b1; acc_valid_i = 1'b1; acc_data_i = w1;
        #1;
        idle_chk("single_pre");
        next_cycle();
        acc_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            beat_chk($sformatf("single_b%0d", i), 32'hA + NW'(i), i == 3);
            next_cycle();
        end
        #1;
        idle_chk("single_post");

        // Three words back to back, no bubbles
        acc_valid_i = 1'b1; acc_data_i = words[0];
        #1;
        next_cycle();
        for (int b = 0; b < 12; b++) begin
            if (b / 4 < 2) begin
                acc_valid_i = 1'b1; acc_data_i = words[b / 4 + 1];
            end else begin
                acc_valid_i = 1'b0;
            end
            #1;
            beat_chk($sformatf("b2b_b%0d", b), 32'h20 + NW'(16 * (b / 4)) + NW'(b % 4), (b % 4) == 3);
            next_cycle();
        end
        acc_valid_i = 1'b0;
        #1;
        idle_chk("b2b_post");

        // Backpressure pattern 1,0,0,1,...
        acc_valid_i = 1'b1; acc_data_i = w5;
        #1;
        next_cycle();
        acc_valid_i = 1'b0;
        exp_i = 0;
        cyc = 0;
        while (exp_i < 4 && cyc < 20) begin
            rdy = ((cyc % 3) == 0);
            stream_ready_i = rdy;
            #1;
            beat_chk($sformatf("bp_c%0d", cyc), 32'h50 + NW'(exp_i), (exp_i == 3) && rdy);
            if (rdy) exp_i++;
            cyc++;
            next_cycle();
        end
        stream_ready_i = 1'b1;
        #1;
        idle_chk("bp_post");

        // Clear at idx 2, with a competing word offered during the clear
        acc_valid_i = 1'b1; acc_data_i = w6;
        #1;
        next_cycle();
        acc_valid_i = 1'b0;
        #1; beat_chk("clr_b0", 32'h60, 1'b0);
        next_cycle();
        #1; beat_chk("clr_b1", 32'h61, 1'b0);
        next_cycle();
        #1; beat_chk("clr_b2", 32'h62, 1'b0);
        clear_i = 1'b1; acc_valid_i = 1'b1; acc_data_i = w7;
        #1;
        chk("clr_same_valid", WW'(stream_valid_o), WW'(1'b0));
        chk("clr_same_ardy", WW'(acc_ready_o), WW'(1'b0));
        next_cycle();
        clear_i = 1'b0; acc_valid_i = 1'b0;
        #1;
        idle_chk("clr_next");
`ifdef SNAX_GEMMX_SER_BEAT_CNT_EN
        chk("clr_cnt", WW'(beat_cnt_o), WW'(32'h0));
`endif
        acc_valid_i = 1'b1; acc_data_i = w7;
        #1;
        next_cycle();
        acc_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            beat_chk($sformatf("clr_w7_b%0d", i), 32'h70 + NW'(i), i == 3);
            next_cycle();
        end
        #1;
        idle_chk("clr_w7_post");
`ifdef SNAX_GEMMX_SER_BEAT_CNT_EN
        chk("clr_w7_cnt", WW'(beat_cnt_o), WW'(32'h4));
`endif

        // Asynchronous reset at idx 1
        acc_valid_i = 1'b1; acc_data_i = w8;
        #1;
        next_cycle();
        acc_valid_i = 1'b0;
        #1; beat_chk("ar_b0", 32'h80, 1'b0);
        next_cycle();
        #1; beat_chk("ar_b1", 32'h81, 1'b0);
        rst_ni = 1'b0;
        #1;
        idle_chk("ar_async");
        chk("ar_async_data", WW'(stream_data_o), WW'(32'h0));
`ifdef SNAX_GEMMX_SER_BEAT_CNT_EN
        chk("ar_async_cnt", WW'(beat_cnt_o), WW'(32'h0));
`endif
        #2 rst_ni = 1'b1;
        next_cycle();
        acc_valid_i = 1'b1; acc_data_i = w1;
        #1;
        next_cycle();
        for (int b = 0; b < 8; b++) begin
            acc_valid_i = (b < 4);
            #1;
            beat_chk($sformatf("ar_w_b%0d", b), 32'hA + NW'(b % 4), (b % 4) == 3);
            next_cycle();
        end
        acc_valid_i = 1'b0;
        #1;
        idle_chk("ar_post");
`ifdef SNAX_GEMMX_SER_BEAT_CNT_EN
        chk("ar_cnt8", WW'(beat_cnt_o), WW'(32'h8));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
